// File: rtl/rsa_uart_sequencer.sv
// UART-fed sequencer for the modular exponentiation datapath.
// Collects an operand, runs one job, sends the result back.
module rsa_uart_sequencer #(
    parameter int WIDTH      = 16,
    parameter int RX_TIMEOUT = 1_000_000,
    parameter int EM_TIMEOUT = 65_536
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rx_valid_in,
    input  logic [7:0]       rx_byte_in,
    input  logic [WIDTH-1:0] key_exponent_in,
    input  logic [WIDTH-1:0] key_modulus_in,
    output logic             em_ready_out,
    output logic [WIDTH-1:0] em_value_out,
    output logic [WIDTH-1:0] em_exponent_out,
    output logic [WIDTH-1:0] em_modulus_out,
    input  logic             em_busy_in,
    input  logic             em_valid_in,
    input  logic [WIDTH-1:0] em_result_in,
    output logic [7:0]       tx_byte_out,
    output logic             tx_trigger_out,
    input  logic             tx_busy_in,
    output logic [WIDTH-1:0] result_out,
    output logic [1:0]       error_out
);

    localparam int NBYTES = WIDTH / 8;
    localparam int BCW    = $clog2(NBYTES + 1);
    localparam int RXW    = $clog2(RX_TIMEOUT + 1);
    localparam int EMW    = $clog2(EM_TIMEOUT + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [BCW-1:0] ALL_BYTES = BCW'(NBYTES);
    localparam logic [RXW-1:0] RX_LAST   = RXW'(RX_TIMEOUT - 1);
    localparam logic [EMW-1:0] EM_LAST   = EMW'(EM_TIMEOUT - 1);

    localparam logic [1:0] ERR_ZMOD = 2'd1;
    localparam logic [1:0] ERR_EMTO = 2'd2;
    localparam logic [1:0] ERR_OVR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        START,
        WAIT,
        SEND,
        TXWAIT
    } state_e;

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_n_int;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [RXW-1:0]   rx_idle_q, rx_idle_d;
    logic [EMW-1:0]   em_cnt_q, em_cnt_d;
    logic             em_ready_q, em_ready_d;
    logic [WIDTH-1:0] em_value_q, em_value_d;
    logic [WIDTH-1:0] em_exp_q, em_exp_d;
    logic [WIDTH-1:0] em_mod_q, em_mod_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] tx_res_q, tx_res_d;
    logic [BCW-1:0]   tx_left_q, tx_left_d;
    logic             tx_first_q, tx_first_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_trig_q, tx_trig_d;
    logic [1:0]       err_q, err_d;
    logic [WIDTH-1:0] op_next;

    // Release pattern for the reset synchroniser
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Asynchronous assert, clock-aligned release of the internal reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Next-state and datapath control for the whole job sequence
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bcnt_d     = bcnt_q;
        rx_idle_d  = rx_idle_q;
        em_cnt_d   = em_cnt_q;
        em_ready_d = 1'b0;
        em_value_d = em_value_q;
        em_exp_d   = em_exp_q;
        em_mod_d   = em_mod_q;
        res_d      = res_q;
        tx_res_d   = tx_res_q;
        tx_left_d  = tx_left_q;
        tx_first_d = tx_first_q;
        tx_byte_d  = tx_byte_q;
        tx_trig_d  = 1'b0;
        err_d      = err_q;
        op_next    = (op_q << 8) | WIDTH'(rx_byte_in);

        // Bytes arriving while a job is in flight are dropped
        if (rx_valid_in && state_q != IDLE && state_q != RECV) begin
            err_d = ERR_OVR;
        end

        case (state_q)
            IDLE, RECV: begin
                if (rx_valid_in) begin
                    rx_idle_d = '0;
                    if (bcnt_q == LAST_BYTE) begin
                        em_value_d = op_next;
                        op_d       = '0;
                        bcnt_d     = '0;
                        state_d    = START;
                    end else begin
                        op_d    = op_next;
                        bcnt_d  = bcnt_q + BCW'(1);
                        state_d = RECV;
                    end
                end else if (state_q == RECV) begin
                    if (rx_idle_q == RX_LAST) begin
                        op_d      = '0;
                        bcnt_d    = '0;
                        rx_idle_d = '0;
                        state_d   = IDLE;
                    end else begin
                        rx_idle_d = rx_idle_q + RXW'(1);
                    end
                end
            end
            START: begin
                em_exp_d = key_exponent_in;
                em_mod_d = key_modulus_in;
                if (key_modulus_in == '0) begin
                    err_d     = ERR_ZMOD;
                    tx_res_d  = '1;
                    tx_left_d = ALL_BYTES;
                    state_d   = SEND;
                end else if (!em_busy_in) begin
                    em_ready_d = 1'b1;
                    em_cnt_d   = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (em_valid_in) begin
                    tx_res_d  = em_result_in;
                    res_d     = em_result_in;
                    tx_left_d = ALL_BYTES;
                    em_cnt_d  = '0;
                    state_d   = SEND;
                end else if (em_cnt_q == EM_LAST) begin
                    err_d    = ERR_EMTO;
                    em_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    em_cnt_d = em_cnt_q + EMW'(1);
                end
            end
            SEND: begin
                if (!tx_busy_in) begin
                    tx_byte_d  = tx_res_q[WIDTH-1 -: 8];
                    tx_res_d   = tx_res_q << 8;
                    tx_left_d  = tx_left_q - BCW'(1);
                    tx_trig_d  = 1'b1;
                    tx_first_d = 1'b1;
                    state_d    = TXWAIT;
                end
            end
            TXWAIT: begin
                // Transmitter raises busy one cycle after the strobe
                if (tx_first_q) begin
                    tx_first_d = 1'b0;
                end else if (!tx_busy_in) begin
                    if (tx_left_q != '0) begin
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= IDLE;
            op_q       <= '0;
            bcnt_q     <= '0;
            rx_idle_q  <= '0;
            em_cnt_q   <= '0;
            em_ready_q <= 1'b0;
            em_value_q <= '0;
            em_exp_q   <= '0;
            em_mod_q   <= '0;
            res_q      <= '0;
            tx_res_q   <= '0;
            tx_left_q  <= '0;
            tx_first_q <= 1'b0;
            tx_byte_q  <= '0;
            tx_trig_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            bcnt_q     <= bcnt_d;
            rx_idle_q  <= rx_idle_d;
            em_cnt_q   <= em_cnt_d;
            em_ready_q <= em_ready_d;
            em_value_q <= em_value_d;
            em_exp_q   <= em_exp_d;
            em_mod_q   <= em_mod_d;
            res_q      <= res_d;
            tx_res_q   <= tx_res_d;
            tx_left_q  <= tx_left_d;
            tx_first_q <= tx_first_d;
            tx_byte_q  <= tx_byte_d;
            tx_trig_q  <= tx_trig_d;
            err_q      <= err_d;
        end
    end

    assign em_ready_out    = em_ready_q;
    assign em_value_out    = em_value_q;
    assign em_exponent_out = em_exp_q;
    assign em_modulus_out  = em_mod_q;
    assign tx_byte_out     = tx_byte_q;
    assign tx_trigger_out  = tx_trig_q;
    assign result_out      = res_q;
    assign error_out       = err_q;

endmodule

// File: doc/rsa_uart_sequencer.md
RSA_UART_SEQUENCER -- requirements
Module: rsa_uart_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/key/result width in bits; a multiple of 8.
REQ-002 SHALL have parameter RX_TIMEOUT, default 1_000_000, meaning idle clock cycles allowed between operand bytes.
REQ-003 SHALL have parameter EM_TIMEOUT, default 65_536, meaning maximum cycles to wait for em_valid_in.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_in  input  1  system clock; rst_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have rx_valid_in  input  1  one-cycle strobe, UART receiver byte ready.
REQ-006 SHALL have rx_byte_in  input  8  received byte, valid with rx_valid_in.
REQ-007 SHALL have key_exponent_in  input  WIDTH  exponent from key store; key_modulus_in  input  WIDTH  modulus from key store.
REQ-008 SHALL have em_ready_out  output  1  one-cycle start pulse to exponent_modulus.
REQ-009 SHALL have em_value_out, em_exponent_out, em_modulus_out  output  WIDTH each  operands held stable from start pulse until job ends.
REQ-010 SHALL have em_busy_in  input  1, em_valid_in  input  1, em_result_in  input  WIDTH  datapath status and result.
REQ-011 SHALL have tx_byte_out  output  8  byte to UART transmitter; tx_trigger_out  output  1  one-cycle send strobe; tx_busy_in  input  1  transmitter busy.
REQ-012 SHALL have result_out  output  WIDTH  last good result (LED display); error_out  output  2  sticky code: 0 none, 1 zero modulus, 2 datapath timeout, 3 rx overrun.

Function
REQ-013 SHALL implement states IDLE, RECV, START, WAIT, SEND, TXWAIT.
REQ-014 IDLE/RECV: each rx_valid_in shifts rx_byte_in into operand register MSB-first; byte counter increments; IDLE->RECV on first byte.
REQ-015 On the WIDTH/8-th byte SHALL latch operand to em_value_out and go to START next cycle; WIDTH=16 means 2 bytes.
REQ-016 RECV with no byte for RX_TIMEOUT consecutive cycles SHALL discard partial operand, clear byte counter, return IDLE; no error code.
REQ-017 START: sample key_exponent_in/key_modulus_in into em_exponent_out/em_modulus_out; if sampled modulus is 0, set error 1, load all-ones tx result, go SEND without pulsing em_ready_out.
REQ-018 START with nonzero modulus SHALL assert em_ready_out for exactly one cycle only when em_busy_in=0, then go WAIT; if em_busy_in=1, stay in START.
REQ-019 WAIT: on em_valid_in SHALL capture em_result_in into tx result register and result_out, go SEND.
REQ-020 WAIT counter reaching EM_TIMEOUT without em_valid_in SHALL set error 2 and return IDLE; nothing transmitted, result_out unchanged.
REQ-021 SEND: when tx_busy_in=0 drive next result byte (MSB first) on tx_byte_out, pulse tx_trigger_out one cycle, go TXWAIT.
REQ-022 TXWAIT: ignore tx_busy_in for the first cycle, then wait for tx_busy_in=0; go SEND if bytes remain, else IDLE.
REQ-023 Operand latency: em_ready_out SHALL pulse 2 cycles after last rx_valid_in when em_busy_in=0 (latch cycle, START cycle).
REQ-024 rx_valid_in in START, WAIT, SEND or TXWAIT SHALL drop the byte and set error 3; it SHALL NOT corrupt the in-flight job.
REQ-025 A new error code SHALL overwrite the previous one; error_out clears only on reset.
REQ-026 em_ready_out and tx_trigger_out SHALL never both be high; each is a single-cycle pulse per transaction.
REQ-027 rx_valid_in coincident with RX_TIMEOUT expiry SHALL count as a byte (timeout not taken).

Reset
REQ-028 rst_in low SHALL asynchronously force IDLE and zero all registers and outputs: em_ready_out=0, tx_trigger_out=0, tx_byte_out=0, em_*_out=0, result_out=0, error_out=0, counters=0.
REQ-029 Reset mid-job SHALL abandon the job; after release the block SHALL accept a fresh operand from byte 0 and send nothing of the old job.
REQ-030 Reset release SHALL be synchronised internally (two-flop) so outputs leave reset on a clk_in edge.

Verification
REQ-031 Bytes 0x00,0x02; key exp 72, mod 1073; model returns 2^72 mod 1073 -> em_ready_out pulse once, result_out=0x0070, tx bytes 0x00 then 0x70.
REQ-032 Modulus 0, bytes 0x12,0x34 -> no em_ready_out, error_out=1, tx bytes 0xFF,0xFF, result_out unchanged.
REQ-033 Byte 0xAB then RX_TIMEOUT idle cycles (RX_TIMEOUT=100), then 0x00,0x05 -> em_value_out=0x0005, 0xAB discarded.
REQ-034 Datapath never asserts em_valid_in (EM_TIMEOUT=50) -> IDLE after 50 WAIT cycles, error_out=2, no tx_trigger_out.
REQ-035 Extra byte 0x55 during WAIT -> error_out=3, job result and tx bytes unaffected.
REQ-036 rst_in low during SEND after first byte -> second byte never triggered, all outputs 0, next job runs normally.
